instruction_fetch_unit: RTL and testbench

Fetch-side reader of the combinational instruction memory. It owns the PC, drives the memory address and captures the returned word together with its PC into a small queue. It presents {pc, instr} to decode over a valid/ready handshake, and supports redirects from branch/jal/jalr resolution. It sits between the instruction memory and the IF/ID pipeline register.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 88 ++++++++
 rtl/instruction_fetch_unit.sv | 88 ++++++++
 tb/tb_instruction_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared constants and the fetch queue entry type for the fetch unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam int          PC_STEP          = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module : fetch_queue
// Brief  : Synchronous FIFO of fetch entries with push, pop and flush.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  entry_t                     wr_data,
  output entry_t                     rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // A push into a full queue is only legal when the head leaves the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : fetch_queue

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module : instruction_fetch_unit
// Brief  : PC owner and instruction memory reader feeding decode via a queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rd,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc
);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  logic [WIDTH-1:0]           pc_q, pc_d;
  logic                       push, pop;
  logic [$clog2(DEPTH+1)-1:0] q_count;
  logic                       q_full;
  logic                       unused_q_empty;
  logic                       unused_redirect_lsbs;
  entry_t                     wr_entry;
  entry_t                     head;

  assign imem_addr = pc_q;
  assign out_valid = (q_count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

  // Redirect wins: the queue is flushed and nothing is fetched that cycle.
  assign pop      = out_valid & out_ready;
  assign push     = ~redirect_valid & (~q_full | pop);
  assign wr_entry = '{pc: pc_q, instr: imem_rd};

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + WIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fetch_queue (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (q_count),
    .full    (q_full),
    .empty   (unused_q_empty)
  );

endmodule : instruction_fetch_unit

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module : tb_instruction_fetch_unit
// Brief  : Self-checking bench for instruction_fetch_unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

  localparam int          WIDTH    = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0020_81B3;
      32'h0000_0004: mem_word = 32'h4032_02B3;
      32'h0000_0008: mem_word = 32'h0030_8383;
      32'h0000_0030: mem_word = 32'h0031_2293;
      default:       mem_word = 32'hA500_0000 ^ a;
    endcase
  endfunction

  assign imem_rd = mem_word(imem_addr);

  instruction_fetch_unit #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  task automatic apply_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset.out_valid got %0b want 0", out_valid); else passes++;
    checks++; if (out_pc !== 32'h0) $display("FAIL reset.out_pc got %h want 0", out_pc); else passes++;
    checks++; if (out_instr !== 32'h0) $display("FAIL reset.out_instr got %h want 0", out_instr); else passes++;
    checks++; if (imem_addr !== RESET_PC) $display("FAIL reset.imem_addr got %h want %h", imem_addr, RESET_PC); else passes++;
  endtask

  task automatic test_free_run();
    sb.delete();
    sb.push_back('{pc: 32'h0, instr: 32'h0020_81B3});
    sb.push_back('{pc: 32'h4, instr: 32'h4032_02B3});
    sb.push_back('{pc: 32'h8, instr: 32'h0030_8383});
    out_ready = 1'b1;
    reset     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_addr !== 32'(i*4)) $display("FAIL free_run.imem_addr[%0d] got %h want %h", i, imem_addr, 32'(i*4)); else passes++;
      checks++; if (out_valid !== (i != 0)) $display("FAIL free_run.out_valid[%0d] got %0b want %0b", i, out_valid, (i != 0)); else passes++;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) $display("FAIL free_run.unexpected_pop got pc %h want none", out_pc);
        else begin
          e = sb.pop_front();
          if (out_pc !== e.pc || out_instr !== e.instr)
            $display("FAIL free_run.head got (%h,%h) want (%h,%h)", out_pc, out_instr, e.pc, e.instr);
          else passes++;
        end
      end
      @(negedge clk);
    end
    checks++; if (sb.size() != 0) $display("FAIL free_run.missing got %0d left want 0", sb.size()); else passes++;
  endtask

  task automatic test_hold();
    apply_reset();
    repeat (5) @(negedge clk);
    checks++; if (out_valid !== 1'b1) $display("FAIL hold.out_valid got %0b want 1", out_valid); else passes++;
    checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0020_81B3) $display("FAIL hold.head got (%h,%h) want (0,002081b3)", out_pc, out_instr); else passes++;
    checks++; if (imem_addr !== 32'h8) $display("FAIL hold.imem_addr got %h want 8", imem_addr); else passes++;
    sb.delete();
    sb.push_back('{pc: 32'h0, instr: 32'h0020_81B3});
    sb.push_back('{pc: 32'h4, instr: 32'h4032_02B3});
    sb.push_back('{pc: 32'h8, instr: 32'h0030_8383});
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1) $display("FAIL hold.release_gap[%0d] got valid %0b want 1", i, out_valid);
      else if (sb.size() == 0) $display("FAIL hold.unexpected_pop got pc %h want none", out_pc);
      else begin
        e = sb.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr)
          $display("FAIL hold.release[%0d] got (%h,%h) want (%h,%h)", i, out_pc, out_instr, e.pc, e.instr);
        else passes++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h18;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h18) $display("FAIL redirect.pre_head got (%0b,%h) want (1,18)", out_valid, out_pc); else passes++;
    checks++; if (imem_addr !== 32'h20) $display("FAIL redirect.pre_addr got %h want 20", imem_addr); else passes++;
    sb.delete();
    sb.push_back('{pc: 32'h20, instr: mem_word(32'h20)});
    sb.push_back('{pc: 32'h24, instr: mem_word(32'h24)});
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    out_ready      = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL redirect.bubble got valid %0b want 0", out_valid); else passes++;
    checks++; if (imem_addr !== 32'h20) $display("FAIL redirect.addr got %h want 20", imem_addr); else passes++;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b1) $display("FAIL redirect.valid[%0d] got %0b want 1", i, out_valid);
      else if (sb.size() == 0) $display("FAIL redirect.unexpected_pop got pc %h want none", out_pc);
      else begin
        e = sb.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr)
          $display("FAIL redirect.head[%0d] got (%h,%h) want (%h,%h)", i, out_pc, out_instr, e.pc, e.instr);
        else passes++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_align();
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0033;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'h30) $display("FAIL align.addr got %h want 30", imem_addr); else passes++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h30 || out_instr !== 32'h0031_2293)
      $display("FAIL align.head got (%0b,%h,%h) want (1,30,00312293)", out_valid, out_pc, out_instr);
    else passes++;
  endtask

  task automatic test_wrap();
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap.addr0 got %h want fffffffc", imem_addr); else passes++;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0) $display("FAIL wrap.addr1 got %h want 0", imem_addr); else passes++;
    checks++;
    if (out_pc !== 32'hFFFF_FFFC || out_instr !== mem_word(32'hFFFF_FFFC))
      $display("FAIL wrap.head0 got (%h,%h) want (fffffffc,%h)", out_pc, out_instr, mem_word(32'hFFFF_FFFC));
    else passes++;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0020_81B3)
      $display("FAIL wrap.head1 got (%0b,%h,%h) want (1,0,002081b3)", out_valid, out_pc, out_instr);
    else passes++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b1) $display("FAIL reset_mid.pre_valid got %0b want 1", out_valid); else passes++;
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_mid.out_valid got %0b want 0", out_valid); else passes++;
    checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0) $display("FAIL reset_mid.head got (%h,%h) want (0,0)", out_pc, out_instr); else passes++;
    checks++; if (imem_addr !== RESET_PC) $display("FAIL reset_mid.addr got %h want %h", imem_addr, RESET_PC); else passes++;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== RESET_PC || imem_addr !== RESET_PC + 32'd4)
      $display("FAIL reset_mid.restart got (%0b,%h,%h) want (1,%h,%h)", out_valid, out_pc, imem_addr, RESET_PC, RESET_PC + 32'd4);
    else passes++;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    test_reset();
    test_free_run();
    test_hold();
    test_redirect();
    test_redirect_align();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_instruction_fetch_unit

`default_nettype wire
